// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM state type and default widths.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF        = 11;
    localparam int INSTRUCTION_WIDTH_DEF = 15;
    localparam int OPCODE_WIDTH          = INSTRUCTION_WIDTH_DEF - DATA_WIDTH_DEF + 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 5'b00000;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 5'b00001;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 5'b00010;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 5'b00011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 5'b00100;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: loads the branch target or increments (wrapping) on load.
module program_counter
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  branch,
    input  logic [DATA_WIDTH-1:0] target,
    output logic [DATA_WIDTH-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= branch ? target : pc + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/WAIT/HALT FSM, instruction register and PC control.
// Optional feature: define FETCH_TIMEOUT_EN to abandon fetches after TIMEOUT_CYCLES without imem_ack.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   fetch_req,
    input  logic                                   pc_wr,
    input  logic                                   branch,
    output logic                                   imem_req,
    output logic [DATA_WIDTH-1:0]                  imem_addr,
    input  logic                                   imem_ack,
    input  logic [INSTRUCTION_WIDTH:0]             imem_data,
    output logic [INSTRUCTION_WIDTH-DATA_WIDTH:0]  op_code,
    output logic [DATA_WIDTH-1:0]                  operand,
    output logic                                   ir_valid,
    output logic                                   fetch_done,
    output logic                                   halted,
    output logic                                   fetch_error
);

    localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH + 1;

    fetch_state_t               state;
    logic [INSTRUCTION_WIDTH:0] ir;
    logic [DATA_WIDTH-1:0]      pc;
    logic                       pc_load;

    assign op_code   = ir[INSTRUCTION_WIDTH:DATA_WIDTH];
    assign operand   = ir[DATA_WIDTH-1:0];
    assign imem_addr = pc;
    // PC moves only between fetches, so an in-flight fetch always sees a stable address.
    assign pc_load   = pc_wr && (state == ST_IDLE);

    program_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .load  (pc_load),
        .branch(branch),
        .target(operand),
        .pc    (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             fetch_error_r;
    assign fetch_error = fetch_error_r;
`else
    // No timeout hardware: the flag can never be raised.
    assign fetch_error = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ir         <= '0;
            ir_valid   <= 1'b0;
            imem_req   <= 1'b0;
            fetch_done <= 1'b0;
            halted     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt       <= '0;
            fetch_error_r <= 1'b0;
`endif
        end else begin
            fetch_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        state    <= ST_WAIT;
                        imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        ir         <= imem_data;
                        ir_valid   <= 1'b1;
                        fetch_done <= 1'b1;
                        imem_req   <= 1'b0;
                        if (imem_data[INSTRUCTION_WIDTH:DATA_WIDTH] == OPW'(OP_HLT)) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        fetch_error_r <= 1'b1;
                        imem_req      <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11: operand/PC width; operand = instruction[DATA_WIDTH-1:0].
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 15: MSB index of the instruction word; op_code = instruction[INSTRUCTION_WIDTH:DATA_WIDTH] (5 bits at defaults).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: imem_ack wait limit, used only with FETCH_TIMEOUT_EN.
REQ-004 SHALL use a single clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 fetch_req  in  1  control requests a fetch at the current PC.
REQ-006 pc_wr  in  1  PC update strobe; branch  in  1  selects branch target (1) vs increment (0).
REQ-007 imem_req  out  1; imem_addr  out  DATA_WIDTH; imem_ack  in  1; imem_data  in  INSTRUCTION_WIDTH+1: instruction memory handshake.
REQ-008 op_code  out  INSTRUCTION_WIDTH-DATA_WIDTH+1; operand  out  DATA_WIDTH: registered instruction fields to decoder/datapath.
REQ-009 ir_valid  out  1  IR holds a fetched instruction; fetch_done  out  1  one-cycle pulse per completed fetch; halted  out  1  HLT fetched.
REQ-010 fetch_error  out  1  sticky timeout flag (tied 0 without FETCH_TIMEOUT_EN).

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, HALT.
REQ-012 IDLE: fetch_req=1 -> WAIT next cycle; imem_req SHALL be a registered output, high in every WAIT cycle and low otherwise.
REQ-013 imem_addr SHALL equal the PC register at all times.
REQ-014 WAIT: imem_ack=1 -> IR <= imem_data, ir_valid <= 1, fetch_done pulses high the following cycle for exactly one cycle, state -> IDLE; latency fetch_req-to-fetch_done = 2 cycles with zero-wait memory.
REQ-015 WAIT: imem_ack=0 -> remain in WAIT, imem_req held high, IR unchanged.
REQ-016 If the captured op_code is HLT (5'b00000), state SHALL go to HALT instead of IDLE and halted SHALL assert; HALT exits only on reset.
REQ-017 pc_wr accepted only in IDLE: branch=1 -> PC <= operand; branch=0 -> PC <= PC+1 modulo 2^DATA_WIDTH (all-ones wraps to 0).
REQ-018 pc_wr in WAIT or HALT SHALL be ignored; fetch_req in WAIT or HALT SHALL be ignored.
REQ-019 pc_wr and fetch_req together in IDLE: both accepted; the fetch SHALL use the updated PC.
REQ-020 imem_ack outside WAIT SHALL be ignored.
REQ-021 op_code/operand SHALL hold their value until the next accepted imem_ack.

Reset
REQ-022 On reset=1 at a clock edge: state IDLE, PC 0, IR 0, ir_valid 0, imem_req 0, fetch_done 0, halted 0, fetch_error 0.
REQ-023 Reset in WAIT SHALL abort the fetch; a subsequent late imem_ack SHALL be ignored.

Configuration
REQ-024 Macro FETCH_TIMEOUT_EN defined: counter clears on WAIT entry, increments per WAIT cycle without ack; reaching TIMEOUT_CYCLES -> fetch_error <= 1 (sticky until reset), state -> IDLE, IR and ir_valid unchanged, no fetch_done.
REQ-025 Macro undefined: no counter, WAIT persists indefinitely, fetch_error constant 0.

Structure
REQ-026 Shared package cpu_pkg SHALL hold opcode constants (HLT..JMP), fetch-state enum type, and default width constants.
REQ-027 PC register with increment/branch mux SHALL be a sub-module program_counter; FSM, IR and timeout stay in fetch_unit.

Verification
REQ-028 Reset, fetch_req at PC 0, imem_ack same cycle WAIT entered, imem_data 16'h1805 -> imem_addr 0, op_code 5'b00011, operand 11'h005, fetch_done one cycle, ir_valid 1.
REQ-029 PC 11'h7FF, pc_wr=1 branch=0 -> PC 0; pc_wr=1 branch=1 with operand 11'h123 -> imem_addr 11'h123.
REQ-030 imem_ack delayed 5 cycles -> imem_req high 5+ cycles, IR unchanged until ack; pc_wr pulsed mid-wait leaves PC unchanged.
REQ-031 Fetch data 16'h0000 -> halted 1, further fetch_req/pc_wr ignored; reset -> halted 0, PC 0.
REQ-032 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES 16, no ack -> fetch_error 1 after 16 WAIT cycles, state IDLE, no fetch_done; reset mid-WAIT then late ack -> IR stays 0.
